// File: rtl/alu_result_stage.sv
// ALU result stage: registers ALUOut, derives N/Z/V/C, resolves branches, single-entry valid/ready buffer.
// Define ALU_OVF_TRAP_EN to build the signed ADD/SUB overflow trap (TRAP state, exc_ovf, exc_epc).
module alu_result_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_overflow,
   input  logic              alu_carry,
   input  logic [2:0]        alu_op,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic              wr_req,
   input  logic [2:0]        br_cond,
   input  logic [DATA_W-1:0] pc_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_AW-1:0] out_dest,
   output logic              out_wr_en,
   output logic              branch_taken,
   output logic [3:0]        flags,
   output logic              exc_ovf,
   output logic [DATA_W-1:0] exc_epc,
   input  logic              exc_ack
);

   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   localparam logic [2:0] BR_EQ  = 3'b001;
   localparam logic [2:0] BR_NE  = 3'b010;
   localparam logic [2:0] BR_LT  = 3'b011;
   localparam logic [2:0] BR_GE  = 3'b100;
   localparam logic [2:0] BR_LEZ = 3'b101;
   localparam logic [2:0] BR_GTZ = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FULL = 2'd1
`ifdef ALU_OVF_TRAP_EN
      , TRAP = 2'd2
`endif
   } state_t;

   state_t state, state_nx;

   logic is_addsub;
   logic n_new, z_new, v_new, c_new;
   logic br_new;
   logic accept, trap_acc, load;

   assign is_addsub = (alu_op == OP_ADD) || (alu_op == OP_SUB);
   assign n_new     = alu_result[DATA_W-1];
   assign z_new     = (alu_result == '0);
   assign v_new     = is_addsub & alu_overflow;
   assign c_new     = is_addsub & alu_carry;

   // Branch decision uses the flags being loaded, not the stale register.
   always_comb begin
      br_new = 1'b0;
      case (br_cond)
         BR_EQ:   br_new = z_new;
         BR_NE:   br_new = ~z_new;
         BR_LT:   br_new = n_new ^ v_new;
         BR_GE:   br_new = ~(n_new ^ v_new);
         BR_LEZ:  br_new = n_new | z_new;
         BR_GTZ:  br_new = ~n_new & ~z_new;
         default: br_new = 1'b0;
      endcase
   end

   assign accept = in_valid & in_ready;

`ifdef ALU_OVF_TRAP_EN
   assign trap_acc = accept & is_addsub & alu_overflow;
`else
   assign trap_acc = 1'b0;
   logic unused_trap_inputs;
   assign unused_trap_inputs = ^{pc_in, exc_ack};
`endif

   assign load = accept & ~trap_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (trap_acc)  state_nx = state_t'(2'd2);
            else if (load) state_nx = FULL;
         end
         FULL: begin
            if (trap_acc)       state_nx = state_t'(2'd2);
            else if (load)      state_nx = FULL;
            else if (out_ready) state_nx = IDLE;
         end
`ifdef ALU_OVF_TRAP_EN
         TRAP: begin
            if (exc_ack) state_nx = IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // A trapping accept from FULL always drains, so no entry survives into TRAP.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         FULL: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result   <= '0;
         out_dest     <= '0;
         out_wr_en    <= 1'b0;
         branch_taken <= 1'b0;
         flags        <= 4'b0000;
      end else begin
         if (accept) flags <= {n_new, z_new, v_new, c_new};
         if (load) begin
            out_result   <= alu_result;
            out_dest     <= dest_reg;
            out_wr_en    <= wr_req;
            branch_taken <= br_new;
         end else if (trap_acc) begin
            out_wr_en    <= 1'b0;
            branch_taken <= 1'b0;
         end
      end
   end

`ifdef ALU_OVF_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_ovf <= 1'b0;
         exc_epc <= '0;
      end else if (trap_acc) begin
         exc_ovf <= 1'b1;
         exc_epc <= pc_in;
      end else if ((state == TRAP) && exc_ack) begin
         exc_ovf <= 1'b0;
         exc_epc <= '0;
      end
   end
`else
   assign exc_ovf = 1'b0;
   assign exc_epc = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table through a scoreboard, plus backpressure, overflow and reset sequences.
module tb_alu_result_stage;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [31:0] alu_result;
   logic        alu_overflow, alu_carry;
   logic [2:0]  alu_op;
   logic [4:0]  dest_reg;
   logic        wr_req;
   logic [2:0]  br_cond;
   logic [31:0] pc_in;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_dest;
   logic        out_wr_en, branch_taken;
   logic [3:0]  flags;
   logic        exc_ovf;
   logic [31:0] exc_epc;
   logic        exc_ack;

   alu_result_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
      .alu_op(alu_op), .dest_reg(dest_reg), .wr_req(wr_req), .br_cond(br_cond),
      .pc_in(pc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_dest(out_dest), .out_wr_en(out_wr_en),
      .branch_taken(branch_taken), .flags(flags),
      .exc_ovf(exc_ovf), .exc_epc(exc_epc), .exc_ack(exc_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] res;
      logic        ovf;
      logic        car;
      logic [4:0]  dest;
      logic        wr;
      logic [2:0]  br;
      logic [3:0]  fl;
      logic        bt;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
      logic        wr;
      logic        bt;
      logic [3:0]  fl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   bit   rand_en = 0;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every drained entry must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got result %0h with empty scoreboard", out_result);
         end else begin
            e = sb.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_dest", out_dest, e.dest);
            chk("out_wr_en", out_wr_en, e.wr);
            chk("branch_taken", branch_taken, e.bt);
            chk("flags", flags, e.fl);
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rand_en) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic drive(input vec_t v, input logic [31:0] pc);
      alu_op = v.op; alu_result = v.res; alu_overflow = v.ovf; alu_carry = v.car;
      dest_reg = v.dest; wr_req = v.wr; br_cond = v.br; pc_in = pc;
   endtask

   task automatic send(input vec_t v, input logic [31:0] pc, input bit push);
      int   n;
      exp_t e;
      @(posedge clk);
      #1;
      drive(v, pc);
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for result %0h", v.res);
            in_valid = 1'b0;
            return;
         end
      end
      if (push) begin
         e.res = v.res; e.dest = v.dest; e.wr = v.wr; e.bt = v.bt; e.fl = v.fl;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain", sb.size(), 0);
   endtask

   initial begin
      vec_t v, v2, vt;

      //         op      result        ovf   car   dst  wr    br      flags    bt
      tbl[0]  = '{3'b100, 32'h00000005, 1'b0, 1'b0, 5'd3, 1'b1, 3'b000, 4'b0000, 1'b0};
      tbl[1]  = '{3'b101, 32'h00000000, 1'b0, 1'b1, 5'd4, 1'b1, 3'b001, 4'b0101, 1'b1};
      tbl[2]  = '{3'b101, 32'h00000000, 1'b0, 1'b1, 5'd4, 1'b0, 3'b010, 4'b0101, 1'b0};
      tbl[3]  = '{3'b101, 32'hFFFFFFFE, 1'b0, 1'b0, 5'd8, 1'b1, 3'b011, 4'b1000, 1'b1};
      tbl[4]  = '{3'b000, 32'h80000000, 1'b1, 1'b1, 5'd9, 1'b1, 3'b100, 4'b1000, 1'b0};
      tbl[5]  = '{3'b001, 32'h12345678, 1'b0, 1'b1, 5'd10, 1'b1, 3'b110, 4'b0000, 1'b1};
      tbl[6]  = '{3'b010, 32'h00000000, 1'b0, 1'b0, 5'd11, 1'b1, 3'b101, 4'b0100, 1'b1};
      tbl[7]  = '{3'b011, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd12, 1'b1, 3'b101, 4'b1000, 1'b1};
      tbl[8]  = '{3'b111, 32'h00000001, 1'b0, 1'b1, 5'd13, 1'b0, 3'b111, 4'b0000, 1'b0};
      tbl[9]  = '{3'b100, 32'h7FFFFFFF, 1'b0, 1'b1, 5'd14, 1'b0, 3'b100, 4'b0001, 1'b1};
      tbl[10] = '{3'b110, 32'h00000001, 1'b1, 1'b1, 5'd15, 1'b1, 3'b010, 4'b0000, 1'b1};
      tbl[11] = '{3'b100, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd31, 1'b1, 3'b110, 4'b1000, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; exc_ack = 1'b0;
      drive(tbl[0], 32'h0);
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_result", out_result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_exc_ovf", exc_ovf, 0);
      rst_n = 1'b1;

      // exc_ack outside TRAP has no effect
      @(posedge clk); #1 exc_ack = 1'b1;
      @(posedge clk); #1 exc_ack = 1'b0;
      @(negedge clk);
      chk("ack_idle_in_ready", in_ready, 1);
      chk("ack_idle_out_valid", out_valid, 0);

      // Table pass with the consumer always ready, then with random backpressure
      for (int i = 0; i < 12; i++) send(tbl[i], 32'h00400000 + 32'(i * 4), 1'b1);
      wait_drain();
      rand_en = 1'b1;
      for (int i = 0; i < 12; i++) send(tbl[i], 32'h00400100 + 32'(i * 4), 1'b1);
      rand_en = 1'b0;
      @(posedge clk); #2 out_ready = 1'b1;
      wait_drain();

      // Backpressure: held entry stays stable, then drain and load in one cycle
      v  = '{3'b100, 32'h00000011, 1'b0, 1'b0, 5'd5, 1'b1, 3'b010, 4'b0000, 1'b1};
      v2 = '{3'b101, 32'h00000022, 1'b0, 1'b1, 5'd6, 1'b1, 3'b001, 4'b0001, 1'b0};
      @(posedge clk); #1 out_ready = 1'b0;
      send(v, 32'h00400200, 1'b1);
      drive(v2, 32'h00400204);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_result", out_result, 32'h11);
         chk("bp_out_dest", out_dest, 5);
         chk("bp_branch", branch_taken, 1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_drain", in_ready, 1);
      sb.push_back('{32'h22, 5'd6, 1'b1, 1'b0, 4'b0001});
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_no_bubble_valid", out_valid, 1);
      wait_drain();

      // Overflowing ADD right behind a draining entry
      vt = '{3'b100, 32'h80000000, 1'b1, 1'b0, 5'd7, 1'b1, 3'b100, 4'b1010, 1'b1};
      send(tbl[0], 32'h00400300, 1'b1);
`ifdef ALU_OVF_TRAP_EN
      send(vt, 32'h00400020, 1'b0);
      @(negedge clk);
      chk("trap_out_valid", out_valid, 0);
      chk("trap_exc_ovf", exc_ovf, 1);
      chk("trap_exc_epc", exc_epc, 32'h00400020);
      chk("trap_flags", flags, 4'b1010);
      chk("trap_wr_en", out_wr_en, 0);
      chk("trap_branch", branch_taken, 0);
      @(posedge clk); #1 drive(tbl[5], 32'h0); in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("trap_in_ready", in_ready, 0);
         chk("trap_hold_ovf", exc_ovf, 1);
         chk("trap_hold_valid", out_valid, 0);
      end
      @(posedge clk); #1 in_valid = 1'b0; exc_ack = 1'b1;
      @(posedge clk); #1 exc_ack = 1'b0;
      @(negedge clk);
      chk("ack_exc_ovf", exc_ovf, 0);
      chk("ack_exc_epc", exc_epc, 0);
      chk("ack_in_ready", in_ready, 1);
      chk("ack_out_valid", out_valid, 0);
`else
      send(vt, 32'h00400020, 1'b1);
      @(negedge clk);
      chk("ovf_out_valid", out_valid, 1);
      chk("ovf_exc_ovf", exc_ovf, 0);
      chk("ovf_exc_epc", exc_epc, 0);
`endif
      wait_drain();

      // Asynchronous reset while FULL
      v = '{3'b100, 32'h80000001, 1'b0, 1'b1, 5'd17, 1'b1, 3'b011, 4'b1001, 1'b1};
      @(posedge clk); #1 out_ready = 1'b0;
      send(v, 32'h00400400, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_full_out_valid", out_valid, 0);
      chk("arst_full_out_result", out_result, 0);
      chk("arst_full_out_dest", out_dest, 0);
      chk("arst_full_wr_en", out_wr_en, 0);
      chk("arst_full_branch", branch_taken, 0);
      chk("arst_full_flags", flags, 0);
      chk("arst_full_in_ready", in_ready, 1);
      sb.delete();
      @(negedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("arst_full_release_ready", in_ready, 1);
      chk("arst_full_release_valid", out_valid, 0);

`ifdef ALU_OVF_TRAP_EN
      // Asynchronous reset while TRAP
      send(vt, 32'h00400040, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_trap_exc_ovf", exc_ovf, 0);
      chk("arst_trap_exc_epc", exc_epc, 0);
      chk("arst_trap_in_ready", in_ready, 1);
      chk("arst_trap_flags", flags, 0);
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("arst_trap_release_ready", in_ready, 1);
`endif

      // Stage works normally after reset
      send(tbl[3], 32'h00400500, 1'b1);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
